coord_scan_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 pixel-to-complex-plane mapper.
- Raster-scans a programmable window and emits one (x, y, re, im) tuple per accepted beat over a valid/ready stream.
- Uses incremental accumulation instead of per-pixel multipliers.
- Latches window parameters once per frame, so register writes never tear a frame. Sits between the control registers and the iteration engines.

---
 rtl/coord_scan_gen_if.sv | 36 +++
 rtl/coord_scan_gen.sv | 174 +++++++++++++++++
 tb/tb_coord_scan_gen.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/coord_scan_gen_if.sv
// rtl/coord_scan_gen_if.sv - coordinate tuple stream between scan generator and iteration engines
interface coord_scan_gen_if #(
   parameter int XY_W   = 10,
   parameter int DATA_W = 32
);
   logic              out_valid;
   logic              out_ready;
   logic [XY_W-1:0]   x;
   logic [XY_W-1:0]   y;
   logic [DATA_W-1:0] re;
   logic [DATA_W-1:0] im;
   logic              last_x;
   logic              last_frame;

   modport master (
      output out_valid,
      output x,
      output y,
      output re,
      output im,
      output last_x,
      output last_frame,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  x,
      input  y,
      input  re,
      input  im,
      input  last_x,
      input  last_frame,
      output out_ready
   );
endinterface

// File: rtl/coord_scan_gen.sv
// rtl/coord_scan_gen.sv - raster scan of a programmable window emitting (x, y, re, im) tuples; optional COORD_SCAN_GEN_FRAME_CNT_EN adds frame_count
module coord_scan_gen #(
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int DATA_W = 32,
   parameter int XY_W   = 10
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              start,
   input  logic              abort,
   input  logic              continuous,
   input  logic [DATA_W-1:0] step,
   input  logic [DATA_W-1:0] re_lower,
   input  logic [DATA_W-1:0] im_upper,
   coord_scan_gen_if.master  m,
   output logic              busy,
   output logic              frame_done
`ifdef COORD_SCAN_GEN_FRAME_CNT_EN
   ,
   output logic [15:0]       frame_count
`endif
);

   localparam logic [XY_W-1:0] X_LAST = XY_W'(H_RES - 1);
   localparam logic [XY_W-1:0] Y_LAST = XY_W'(V_RES - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic              valid_q, valid_d;
   logic [XY_W-1:0]   x_q, x_d;
   logic [XY_W-1:0]   y_q, y_d;
   logic [DATA_W-1:0] re_q, re_d;
   logic [DATA_W-1:0] im_q, im_d;
   logic [DATA_W-1:0] step_q, step_d;
   logic [DATA_W-1:0] re_lo_q, re_lo_d;
   logic [DATA_W-1:0] im_up_q, im_up_d;
   logic              done_q, done_d;

   logic              accept;
   logic              last_x_w;
   logic              last_frame_w;
   logic              launch;

   // Flags come straight from the registered position so they track the beat on the bus
   always_comb begin
      last_x_w     = valid_q && (x_q == X_LAST);
      last_frame_w = last_x_w && (y_q == Y_LAST);
      accept       = valid_q && m.out_ready;
   end

   // Next-state and datapath: start/restart latches the window, accepted beats advance the raster
   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      x_d      = x_q;
      y_d      = y_q;
      re_d     = re_q;
      im_d     = im_q;
      step_d   = step_q;
      re_lo_d  = re_lo_q;
      im_up_d  = im_up_q;
      done_d   = 1'b0;
      launch   = 1'b0;

      unique case (state_q)
         IDLE: begin
            // abort held with start keeps the generator parked
            if (start && !abort) begin
               state_d = RUN;
               launch  = 1'b1;
            end
         end
         RUN: begin
            if (abort) begin
               // the beat on the bus this cycle is dropped, not delivered
               state_d = IDLE;
               valid_d = 1'b0;
            end else if (accept) begin
               if (last_frame_w) begin
                  done_d = 1'b1;
                  if (continuous) begin
                     launch = 1'b1;
                  end else begin
                     state_d = IDLE;
                     valid_d = 1'b0;
                  end
               end else if (last_x_w) begin
                  x_d  = '0;
                  y_d  = y_q + 1'b1;
                  re_d = re_lo_q;
                  im_d = im_q - step_q;
               end else begin
                  x_d  = x_q + 1'b1;
                  re_d = re_q + step_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase

      // New frame: window taken from the live inputs so register writes land on frame boundaries
      if (launch) begin
         step_d  = step;
         re_lo_d = re_lower;
         im_up_d = im_upper;
         valid_d = 1'b1;
         x_d     = '0;
         y_d     = '0;
         re_d    = re_lower;
         im_d    = im_upper;
      end
   end

   // State, window latch and output registers
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         re_q    <= '0;
         im_q    <= '0;
         step_q  <= '0;
         re_lo_q <= '0;
         im_up_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         x_q     <= x_d;
         y_q     <= y_d;
         re_q    <= re_d;
         im_q    <= im_d;
         step_q  <= step_d;
         re_lo_q <= re_lo_d;
         im_up_q <= im_up_d;
         done_q  <= done_d;
      end
   end

`ifdef COORD_SCAN_GEN_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   // Completed-frame counter; aborted frames never raise frame_done so they are not counted
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         frame_cnt_q <= '0;
      end else if (done_q) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign frame_count = frame_cnt_q;
`endif

   assign m.out_valid  = valid_q;
   assign m.x          = x_q;
   assign m.y          = y_q;
   assign m.re         = re_q;
   assign m.im         = im_q;
   assign m.last_x     = last_x_w;
   assign m.last_frame = last_frame_w;
   assign busy         = (state_q == RUN);
   assign frame_done   = done_q;

endmodule

// File: tb/tb_coord_scan_gen.sv
// tb/tb_coord_scan_gen.sv - directed self-checking bench for coord_scan_gen on a 4x3 window
`timescale 1ns/1ps
module tb_coord_scan_gen;

   localparam int H = 4;
   localparam int V = 3;

   localparam logic [31:0] ONE  = 32'h0020_0000;
   localparam logic [31:0] MTWO = 32'hFFC0_0000;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        start;
   logic        abort;
   logic        continuous;
   logic [31:0] step;
   logic [31:0] re_lower;
   logic [31:0] im_upper;
   logic        busy;
   logic        frame_done;
`ifdef COORD_SCAN_GEN_FRAME_CNT_EN
   logic [15:0] frame_count;
`endif

   int n_checks = 0;
   int n_errors = 0;

   coord_scan_gen_if #(.XY_W(10), .DATA_W(32)) sif ();

   coord_scan_gen #(
      .H_RES (H),
      .V_RES (V),
      .DATA_W(32),
      .XY_W  (10)
   ) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .start      (start),
      .abort      (abort),
      .continuous (continuous),
      .step       (step),
      .re_lower   (re_lower),
      .im_upper   (im_upper),
      .m          (sif),
      .busy       (busy),
      .frame_done (frame_done)
`ifdef COORD_SCAN_GEN_FRAME_CNT_EN
      ,
      .frame_count(frame_count)
`endif
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge with the frame's first beat already on the bus; returns at the negedge after the last acceptance
   task automatic run_frame(input string name, input bit rnd, input logic [31:0] rl,
                            input logic [31:0] iu, input logic [31:0] st, input bit spot);
      int k;
      int cyc;
      int ex;
      int ey;
      logic r;
      logic [31:0] re_e;
      logic [31:0] im_e;
      k   = 0;
      cyc = 0;
      while (k < H * V && cyc < 400) begin
         r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         sif.out_ready = r;
         if (sif.out_valid) begin
            ex   = k % H;
            ey   = k / H;
            re_e = rl + st * 32'(ex);
            im_e = iu - st * 32'(ey);
            check({name, "_x"}, 64'(sif.x), 64'(ex));
            check({name, "_y"}, 64'(sif.y), 64'(ey));
            check({name, "_re"}, 64'(sif.re), 64'(re_e));
            check({name, "_im"}, 64'(sif.im), 64'(im_e));
            check({name, "_last_x"}, 64'(sif.last_x), 64'(ex == H - 1));
            check({name, "_last_frame"}, 64'(sif.last_frame), 64'(ex == H - 1 && ey == V - 1));
            if (spot && ex == 3 && ey == 0) check({name, "_re_3_0"}, 64'(sif.re), 64'h0020_0000);
            if (spot && ex == 0 && ey == 2) begin
               check({name, "_re_0_2"}, 64'(sif.re), 64'hFFC0_0000);
               check({name, "_im_0_2"}, 64'(sif.im), 64'hFFE0_0000);
            end
            if (r) k++;
         end
         @(negedge aclk);
         cyc++;
      end
      check({name, "_beats"}, 64'(k), 64'(H * V));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge aclk);
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      aresetn       = 1'b0;
      start         = 1'b0;
      abort         = 1'b0;
      continuous    = 1'b0;
      step          = ONE;
      re_lower      = MTWO;
      im_upper      = ONE;
      sif.out_ready = 1'b0;
      @(negedge aclk);
      @(negedge aclk);

      check("rst_valid", 64'(sif.out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(frame_done), 64'd0);
      check("rst_x", 64'(sif.x), 64'd0);
      check("rst_re", 64'(sif.re), 64'd0);
      check("rst_last_frame", 64'(sif.last_frame), 64'd0);
      aresetn = 1'b1;
      @(negedge aclk);

      // Plain frame, always ready
      pulse_start();
      check("f1_first_valid", 64'(sif.out_valid), 64'd1);
      check("f1_busy", 64'(busy), 64'd1);
      run_frame("f1", 1'b0, MTWO, ONE, ONE, 1'b1);
      check("f1_done", 64'(frame_done), 64'd1);
      check("f1_valid_after", 64'(sif.out_valid), 64'd0);
      check("f1_busy_after", 64'(busy), 64'd0);
      @(negedge aclk);
      check("f1_done_pulse", 64'(frame_done), 64'd0);

      // Backpressure
      pulse_start();
      run_frame("bp", 1'b1, MTWO, ONE, ONE, 1'b1);
      check("bp_done", 64'(frame_done), 64'd1);
      check("bp_valid_after", 64'(sif.out_valid), 64'd0);

      // Continuous with a mid-frame window write
      @(negedge aclk);
      continuous = 1'b1;
      pulse_start();
      re_lower = 32'h0;
      run_frame("c1", 1'b1, MTWO, ONE, ONE, 1'b0);
      check("c1_done", 64'(frame_done), 64'd1);
      check("c2_no_bubble", 64'(sif.out_valid), 64'd1);
      check("c2_x0", 64'(sif.x), 64'd0);
      check("c2_y0", 64'(sif.y), 64'd0);
      check("c2_re0", 64'(sif.re), 64'd0);
      continuous = 1'b0;
      run_frame("c2", 1'b0, 32'h0, ONE, ONE, 1'b0);
      check("c2_done", 64'(frame_done), 64'd1);
      check("c2_valid_after", 64'(sif.out_valid), 64'd0);

      // Abort at beat (1,1) while ready
      re_lower = MTWO;
      @(negedge aclk);
      sif.out_ready = 1'b1;
      pulse_start();
      for (int c = 0; c < 20 && !(sif.x == 10'd1 && sif.y == 10'd1); c++) @(negedge aclk);
      check("ab_reach_x", 64'(sif.x), 64'd1);
      check("ab_reach_y", 64'(sif.y), 64'd1);
      abort = 1'b1;
      @(negedge aclk);
      abort = 1'b0;
      check("ab_valid", 64'(sif.out_valid), 64'd0);
      check("ab_busy", 64'(busy), 64'd0);
      check("ab_no_done", 64'(frame_done), 64'd0);
      @(negedge aclk);
      check("ab_no_done2", 64'(frame_done), 64'd0);

      // Abort together with start in idle keeps it idle
      start = 1'b1;
      abort = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      abort = 1'b0;
      check("ab_idle_valid", 64'(sif.out_valid), 64'd0);
      check("ab_idle_busy", 64'(busy), 64'd0);

      // Restart after abort begins at (0,0)
      pulse_start();
      run_frame("rs", 1'b0, MTWO, ONE, ONE, 1'b0);
      check("rs_done", 64'(frame_done), 64'd1);

      // Wrapping arithmetic
      step     = 32'h7FFF_FFFF;
      re_lower = 32'h7FFF_FFFF;
      sif.out_ready = 1'b0;
      @(negedge aclk);
      pulse_start();
      check("wr_re0", 64'(sif.re), 64'h7FFF_FFFF);
      sif.out_ready = 1'b1;
      @(negedge aclk);
      check("wr_x1", 64'(sif.x), 64'd1);
      check("wr_re1", 64'(sif.re), 64'hFFFF_FFFE);
      abort = 1'b1;
      @(negedge aclk);
      abort = 1'b0;

      // Asynchronous reset mid-frame
      step     = ONE;
      re_lower = MTWO;
      pulse_start();
      @(negedge aclk);
      @(negedge aclk);
      #2;
      aresetn = 1'b0;
      #1;
      check("ar_valid", 64'(sif.out_valid), 64'd0);
      check("ar_busy", 64'(busy), 64'd0);
      check("ar_x", 64'(sif.x), 64'd0);
      check("ar_y", 64'(sif.y), 64'd0);
      check("ar_re", 64'(sif.re), 64'd0);
      check("ar_im", 64'(sif.im), 64'd0);
      check("ar_last_x", 64'(sif.last_x), 64'd0);
      check("ar_done", 64'(frame_done), 64'd0);
`ifdef COORD_SCAN_GEN_FRAME_CNT_EN
      check("ar_frame_count", 64'(frame_count), 64'd0);
`endif
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
